// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Pure declarations: no latency, no flow control.
// Backpressure: none.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Gate-level full adder: the only arithmetic cell in the serial adder.
// Latency: combinational.
// Backpressure: none.
module fa_cell (
    output logic SUM,
    output logic COUT,
    input  logic A,
    input  logic B,
    input  logic CIN
);

    logic p;
    logic g;
    logic t;

    xor x_prop (p, A, B);
    xor x_sum  (SUM, p, CIN);
    and a_gen  (g, A, B);
    and a_prop (t, p, CIN);
    or  o_cout (COUT, g, t);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one fa_cell time-shared LSB-first over W cycles; SERIAL_ADD_SUB_EN adds a SUB port (A-B).
// Latency: DONE in the cycle W edges after the accepting edge; BUSY covers W+1 cycles.
// Backpressure: START is only accepted in IDLE; requests while BUSY are dropped, not queued.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         SUB,
`endif
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] SUM,
    output logic         COUT
);

    localparam int CW = $clog2(W);

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          step;
    logic          last;

    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;
    logic [W-1:0]  sh_s;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          cell_sum;
    logic          cell_cout;
    logic          sub_in;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = SUB;
`else
    assign sub_in = 1'b0;
`endif

    assign last = (cnt == CW'(W - 1));
    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    fa_cell u_cell (
        .SUM  (cell_sum),
        .COUT (cell_cout),
        .A    (sh_a[0]),
        .B    (sh_b[0]),
        .CIN  (carry)
    );

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry with 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            SUM   <= '0;
            COUT  <= 1'b0;
        end else if (load) begin
            sh_a  <= A;
            sh_b  <= sub_in ? ~B : B;
            carry <= sub_in;
            cnt   <= '0;
        end else if (step) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sh_s  <= {cell_sum, sh_s[W-1:1]};
            carry <= cell_cout;
            cnt   <= cnt + 1'b1;
            // Result lands on the edge that enters FIN, so SUM holds through SHIFT.
            if (last) begin
                SUM  <= {cell_sum, sh_s[W-1:1]};
                COUT <= cell_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic model.
// Covers SERIAL_ADD_SUB_EN when the macro is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         SUB;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         COUT;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_add_ctrl #(.W(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADD_SUB_EN
        .SUB   (SUB),
`endif
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, {cout, sum}.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int unsigned ai;
        int unsigned bi;
        logic [W:0] r;
        ai = a;
        bi = b;
        if (sub) begin
            r[W-1:0] = W'((ai + (1 << W) - bi) % (1 << W));
            r[W]     = (ai >= bi);
        end else begin
            r = (W+1)'(ai + bi);
        end
        return r;
    endfunction

    // Caller is positioned at a negedge; START is driven in this cycle.
    // ign_at > 0 pulses a second (ignored) START that many cycles after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int ign_at);
        logic [W:0] exp;
        int n;
        int done_at;
        exp = ref_op(a, b, sub);
        A = a;
        B = b;
        SUB = sub;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        SUB = 1'($urandom);
        n = 1;
        done_at = 0;
        while (n <= W + 3 && done_at == 0) begin
            if (DONE) begin
                done_at = n;
                chk("sum", 32'(SUM), 32'(exp[W-1:0]));
                chk("cout", 32'(COUT), 32'(exp[W]));
                chk("busy_fin", 32'(BUSY), 32'd1);
            end else begin
                chk("busy", 32'(BUSY), 32'd1);
                chk("sum_hold", 32'(SUM), 32'(prev_sum));
                chk("cout_hold", 32'(COUT), 32'(prev_cout));
            end
            START = (n == ign_at) ? 1'b1 : 1'b0;
            if (n == ign_at) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        chk("done_lat", 32'(done_at), 32'(W + 1));
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_done", 32'(DONE), 32'd0);
        chk("idle_sum", 32'(SUM), 32'(exp[W-1:0]));
        prev_sum = exp[W-1:0];
        prev_cout = exp[W];
    endtask

    task automatic reset_abort(input logic [W-1:0] a, input logic [W-1:0] b, input int rst_at);
        int seen;
        A = a;
        B = b;
        SUB = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 1; i < rst_at; i++) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_busy", 32'(BUSY), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (DONE) seen++;
            @(negedge CLK);
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        chk("rst_sum", 32'(SUM), 32'd0);
        chk("rst_cout", 32'(COUT), 32'd0);
        prev_sum = '0;
        prev_cout = 1'b0;
    endtask

    initial begin
        logic sub_r;
        RST = 1'b1;
        START = 1'b0;
        A = '0;
        B = '0;
        SUB = 1'b0;
        prev_sum = '0;
        prev_cout = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_busy0", 32'(BUSY), 32'd0);
        chk("rst_done0", 32'(DONE), 32'd0);
        chk("rst_sum0", 32'(SUM), 32'd0);
        chk("rst_cout0", 32'(COUT), 32'd0);

        run_op(8'h00, 8'h00, 1'b0, 0);
        @(negedge CLK);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b0, 0);
        @(negedge CLK);
        run_op(8'h3C, 8'h03, 1'b0, 3);
        run_op(8'h01, 8'h01, 1'b0, 0);
        @(negedge CLK);
        reset_abort(8'h80, 8'h80, 4);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 0);
        run_op(8'h01, 8'h02, 1'b1, 0);
        run_op(8'h55, 8'h55, 1'b1, 0);
`endif

        for (int k = 0; k < 24; k++) begin
            sub_r = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_r = 1'($urandom);
`endif
            if ($urandom_range(0, 1) == 1) @(negedge CLK);
            run_op(W'($urandom), W'($urandom), sub_r,
                   ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, W)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
